regfile_rename: RTL and testbench
=================================

# regfile_rename

Architectural register file with per-register rename status for the Tomasulo core. It sits between the decoder, which renames destinations and queries source operands, and the reorder buffer, which retires results through the commit port. It holds 32×32-bit values plus, per register, a busy bit and the ROB tag of the youngest in-flight writer. Flush clears every rename after a mispredict.

## Interface
- `NUM_REGS`, default 32: architectural register count; x0 is hardwired to zero.
- `DATA_W`, default 32: register value width.
- `TAG_W`, default 4: ROB tag width. Tag 0 is reserved for "no tag"; valid tags are 1..15.

Ports:
- `in_clk`  in  1  single clock; all state updates on the rising edge.
- `in_rst`  in  1  synchronous, active-low reset.
- `in_rdy`  in  1  global stall; when low, all state holds.
- `in_flush_enable`  in  1  mispredict flush from the ROB.
- `in_decoder_rename_enable`  in  1  decoder allocates a ROB entry that writes rd.
- `in_decoder_rd`  in  5  destination register being renamed.
- `in_decoder_reorder`  in  TAG_W  ROB tag assigned, equal to the ROB tail.
- `in_decoder_rs`, `in_decoder_rt`  in  5  source register indices.
- `out_decoder_rs_busy`, `out_decoder_rt_busy`  out  1  source is pending on an in-flight ROB entry.
- `out_decoder_rs_reorder`, `out_decoder_rt_reorder`  out  TAG_W  pending tag; 0 when not busy.
- `out_decoder_rs_value`, `out_decoder_rt_value`  out  DATA_W  register value; valid when not busy.
- `in_rob_commit_enable`  in  1  retire writes a register.
- `in_rob_commit_rd`  in  5  retired destination.
- `in_rob_commit_value`  in  DATA_W  retired result.
- `in_rob_commit_reorder`  in  TAG_W  tag of the retiring entry.

## Operation
- **Reset** (`in_rst`=0 at an edge): all values 0, all busy bits 0, all tags 0. Reset wins over `in_rdy` and every other input. Reset has no output registers; read outputs follow the cleared state in the next cycle.
- **Commit** (enable && rdy && rd≠0):
  - value[rd] ← commit value, unconditionally.
  - If tag[rd] == commit tag, busy[rd] ← 0 and tag[rd] ← 0.
  - Otherwise the rename state is kept, because a younger writer is pending.
- **Rename** (enable && rdy && !flush && rd≠0): busy[rd] ← 1, tag[rd] ← in_decoder_reorder.
- **Same-cycle rename and commit to the same rd**: rename wins for busy/tag; the commit still writes the value.
- **Flush** (flush && rdy):
  - The commit in the same cycle is applied first. The ROB asserts flush together with the JAL/JALR commit.
  - Then every busy bit and tag is cleared.
  - A rename in the flush cycle is dropped.
- **x0**: never busy, tag 0, reads 0. Writes and renames to x0 are ignored.
- **Read ports** are combinational from registered state, with commit bypass:
  - If commit_enable && commit_rd == src ≠ 0 && commit tag == tag[src], output busy=0, tag=0, value=commit value.
  - Otherwise output the stored busy, tag and value.
  - A rename in the same cycle is not visible. For `addi x1,x1,1`, rs reads the old x1 state.
- **Stall** (`in_rdy`=0): no state changes. Read outputs stay live, but the bypass is disabled.
- When busy=1, the decoder forwards the tag to the ROB's ready/value query. This block does not track ROB readiness.

## Timing
- Read latency: 0 cycles (combinational).
- Write/rename latency: state is visible on reads from the cycle after the edge.
- Commit visibility: same cycle via the bypass, and from the stored state on the next cycle.
- No handshakes; all enables are single-cycle pulses qualified by `in_rdy`.
- Tag wrap-around: tags are reused after 15 allocations. The tag-match rule on commit is sufficient because the ROB never holds two live entries with the same tag.

## Structure
- Shared constants in `def.v`: `REG_WIDTH`, `DATA_WIDTH`, `ROB_WIDTH`, `ZERO_DATA`, `TRUE`/`FALSE`, plus a new `NO_REORDER` (0).
- One sub-module, `regfile_read_port`: the source mux plus commit-bypass logic, instantiated twice (rs and rt).
- Storage is three arrays: value, busy, tag.

## Test plan
- **Reset**: hold `in_rst`=0 for 2 cycles, then read x5 → busy=0, tag=0, value=0.
- **Rename then commit**: rename x3 with tag 7; next cycle rs=x3 → busy=1, tag=7. Commit x3=0xDEADBEEF with tag 7 → same-cycle read gives busy=0, value 0xDEADBEEF; the next cycle shows the same from stored state.
- **Stale commit**: rename x4 tag 2, then x4 tag 5. Commit x4=0x11 with tag 2 → value 0x11 stored, but busy=1 and tag=5 remain. Commit with tag 5 then clears busy.
- **Simultaneous rename and commit on x6**: pending tag 3; commit tag 3 value 0x22 in the same cycle as a rename with tag 9 → next cycle busy=1, tag=9, value=0x22.
- **Flush**: rename x1 tag 4 and x2 tag 8. Flush together with commit x1=0x40 tag 4, plus a rename of x7 tag 9 in the same cycle → all busy=0, x1=0x40, x7 not busy.
- **x0 and stall**:
  - Rename and commit on x0 → it reads 0 and is never busy.
  - With `in_rdy`=0, rename x9 → no change after the edge.

Source files
------------

// File: rtl/regfile_rename_pkg.sv
// Shared constants for the rename-aware architectural register file.
package regfile_rename_pkg;

    localparam int REG_WIDTH  = 5;
    localparam int DATA_WIDTH = 32;
    localparam int ROB_WIDTH  = 4;

    localparam logic [DATA_WIDTH-1:0] ZERO_DATA  = '0;
    localparam logic [ROB_WIDTH-1:0]  NO_REORDER = '0;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/regfile_read_port.sv
// One source-operand read port: selects the stored rename state of a register
// and overrides it with a same-cycle retiring result when the tags match.
module regfile_read_port
    import regfile_rename_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = DATA_WIDTH,
    parameter int TAG_W    = ROB_WIDTH
) (
    input  logic [REG_WIDTH-1:0]             src,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  reg_values,
    input  logic [NUM_REGS-1:0]              reg_busy,
    input  logic [NUM_REGS-1:0][TAG_W-1:0]   reg_tags,
    input  logic                             bypass_enable,
    input  logic [REG_WIDTH-1:0]             commit_rd,
    input  logic [DATA_W-1:0]                commit_value,
    input  logic [TAG_W-1:0]                 commit_reorder,
    output logic                             busy,
    output logic [TAG_W-1:0]                 reorder,
    output logic [DATA_W-1:0]                value
);

    logic              stored_busy;
    logic [TAG_W-1:0]  stored_tag;
    logic [DATA_W-1:0] stored_value;
    logic              bypass_hit;

    always_comb begin
        stored_busy  = FALSE;
        stored_tag   = TAG_W'(NO_REORDER);
        stored_value = DATA_W'(ZERO_DATA);
        if (src != '0) begin
            stored_busy  = reg_busy[src];
            stored_tag   = reg_tags[src];
            stored_value = reg_values[src];
        end
    end

    // A stale commit (older tag than the pending writer) must not unmask the
    // register, so the bypass only fires on an exact tag match.
    assign bypass_hit = bypass_enable && (commit_rd == src) && (src != '0)
                        && (commit_reorder == stored_tag);

    always_comb begin
        busy    = stored_busy;
        reorder = stored_tag;
        value   = stored_value;
        if (bypass_hit) begin
            busy    = FALSE;
            reorder = TAG_W'(NO_REORDER);
            value   = commit_value;
        end
    end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register busy bit and youngest-writer
// ROB tag, fed by decoder renames and ROB commits, cleared on flush.
module regfile_rename
    import regfile_rename_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = DATA_WIDTH,
    parameter int TAG_W    = ROB_WIDTH
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_rdy,
    input  logic                 in_flush_enable,
    input  logic                 in_decoder_rename_enable,
    input  logic [REG_WIDTH-1:0] in_decoder_rd,
    input  logic [TAG_W-1:0]     in_decoder_reorder,
    input  logic [REG_WIDTH-1:0] in_decoder_rs,
    input  logic [REG_WIDTH-1:0] in_decoder_rt,
    output logic                 out_decoder_rs_busy,
    output logic                 out_decoder_rt_busy,
    output logic [TAG_W-1:0]     out_decoder_rs_reorder,
    output logic [TAG_W-1:0]     out_decoder_rt_reorder,
    output logic [DATA_W-1:0]    out_decoder_rs_value,
    output logic [DATA_W-1:0]    out_decoder_rt_value,
    input  logic                 in_rob_commit_enable,
    input  logic [REG_WIDTH-1:0] in_rob_commit_rd,
    input  logic [DATA_W-1:0]    in_rob_commit_value,
    input  logic [TAG_W-1:0]     in_rob_commit_reorder
);

    logic [NUM_REGS-1:0][DATA_W-1:0] value_q;
    logic [NUM_REGS-1:0]             busy_q;
    logic [NUM_REGS-1:0][TAG_W-1:0]  tag_q;

    logic bypass_enable;

    assign bypass_enable = in_rob_commit_enable && in_rdy;

    // Per register: commit writes the value first, then flush clears rename
    // state, else a rename claims it, else a matching commit releases it.
    // x0 is only ever touched by reset, so it stays zero and never busy.
    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                value_q[i] <= DATA_W'(ZERO_DATA);
                busy_q[i]  <= FALSE;
                tag_q[i]   <= TAG_W'(NO_REORDER);
            end
        end else if (in_rdy) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (in_rob_commit_enable && (in_rob_commit_rd == REG_WIDTH'(i))) begin
                    value_q[i] <= in_rob_commit_value;
                end
                if (in_flush_enable) begin
                    busy_q[i] <= FALSE;
                    tag_q[i]  <= TAG_W'(NO_REORDER);
                end else if (in_decoder_rename_enable
                             && (in_decoder_rd == REG_WIDTH'(i))) begin
                    busy_q[i] <= TRUE;
                    tag_q[i]  <= in_decoder_reorder;
                end else if (in_rob_commit_enable
                             && (in_rob_commit_rd == REG_WIDTH'(i))
                             && (tag_q[i] == in_rob_commit_reorder)) begin
                    busy_q[i] <= FALSE;
                    tag_q[i]  <= TAG_W'(NO_REORDER);
                end
            end
        end
    end

    regfile_read_port #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .TAG_W    (TAG_W)
    ) u_rs_port (
        .src            (in_decoder_rs),
        .reg_values     (value_q),
        .reg_busy       (busy_q),
        .reg_tags       (tag_q),
        .bypass_enable  (bypass_enable),
        .commit_rd      (in_rob_commit_rd),
        .commit_value   (in_rob_commit_value),
        .commit_reorder (in_rob_commit_reorder),
        .busy           (out_decoder_rs_busy),
        .reorder        (out_decoder_rs_reorder),
        .value          (out_decoder_rs_value)
    );

    regfile_read_port #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .TAG_W    (TAG_W)
    ) u_rt_port (
        .src            (in_decoder_rt),
        .reg_values     (value_q),
        .reg_busy       (busy_q),
        .reg_tags       (tag_q),
        .bypass_enable  (bypass_enable),
        .commit_rd      (in_rob_commit_rd),
        .commit_value   (in_rob_commit_value),
        .commit_reorder (in_rob_commit_reorder),
        .busy           (out_decoder_rt_busy),
        .reorder        (out_decoder_rt_reorder),
        .value          (out_decoder_rt_value)
    );

endmodule

// File: tb/tb_regfile_rename.sv
// Directed self-checking bench for regfile_rename: reset, rename/commit,
// stale commits, same-cycle collisions, flush, x0 and stall behaviour.
module tb_regfile_rename;

    logic        in_clk;
    logic        in_rst;
    logic        in_rdy;
    logic        in_flush_enable;
    logic        in_decoder_rename_enable;
    logic [4:0]  in_decoder_rd;
    logic [3:0]  in_decoder_reorder;
    logic [4:0]  in_decoder_rs;
    logic [4:0]  in_decoder_rt;
    logic        out_decoder_rs_busy;
    logic        out_decoder_rt_busy;
    logic [3:0]  out_decoder_rs_reorder;
    logic [3:0]  out_decoder_rt_reorder;
    logic [31:0] out_decoder_rs_value;
    logic [31:0] out_decoder_rt_value;
    logic        in_rob_commit_enable;
    logic [4:0]  in_rob_commit_rd;
    logic [31:0] in_rob_commit_value;
    logic [3:0]  in_rob_commit_reorder;

    int tests_run;
    int tests_failed;

    regfile_rename dut (
        .in_clk                   (in_clk),
        .in_rst                   (in_rst),
        .in_rdy                   (in_rdy),
        .in_flush_enable          (in_flush_enable),
        .in_decoder_rename_enable (in_decoder_rename_enable),
        .in_decoder_rd            (in_decoder_rd),
        .in_decoder_reorder       (in_decoder_reorder),
        .in_decoder_rs            (in_decoder_rs),
        .in_decoder_rt            (in_decoder_rt),
        .out_decoder_rs_busy      (out_decoder_rs_busy),
        .out_decoder_rt_busy      (out_decoder_rt_busy),
        .out_decoder_rs_reorder   (out_decoder_rs_reorder),
        .out_decoder_rt_reorder   (out_decoder_rt_reorder),
        .out_decoder_rs_value     (out_decoder_rs_value),
        .out_decoder_rt_value     (out_decoder_rt_value),
        .in_rob_commit_enable     (in_rob_commit_enable),
        .in_rob_commit_rd         (in_rob_commit_rd),
        .in_rob_commit_value      (in_rob_commit_value),
        .in_rob_commit_reorder    (in_rob_commit_reorder)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic idle_inputs();
        in_flush_enable          = 1'b0;
        in_decoder_rename_enable = 1'b0;
        in_decoder_rd            = 5'd0;
        in_decoder_reorder       = 4'd0;
        in_rob_commit_enable     = 1'b0;
        in_rob_commit_rd         = 5'd0;
        in_rob_commit_value      = 32'd0;
        in_rob_commit_reorder    = 4'd0;
    endtask

    // Advance past the next rising edge; inputs are then driven mid-cycle.
    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] tag);
        in_decoder_rename_enable = 1'b1;
        in_decoder_rd            = rd;
        in_decoder_reorder       = tag;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] val, input logic [3:0] tag);
        in_rob_commit_enable  = 1'b1;
        in_rob_commit_rd      = rd;
        in_rob_commit_value   = val;
        in_rob_commit_reorder = tag;
    endtask

    task automatic test_reset();
        in_rst = 1'b0;
        in_rdy = 1'b1;
        idle_inputs();
        tick();
        tick();
        in_rst = 1'b1;
        in_decoder_rs = 5'd5;
        in_decoder_rt = 5'd31;
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %0b want 0", out_decoder_rs_busy); end
        tests_run++; if (out_decoder_rs_reorder !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_tag: got %0d want 0", out_decoder_rs_reorder); end
        tests_run++; if (out_decoder_rs_value !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_value: got %h want 0", out_decoder_rs_value); end
        tests_run++; if (out_decoder_rt_value !== 32'd0 || out_decoder_rt_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_x31: got busy %0b value %h want 0/0", out_decoder_rt_busy, out_decoder_rt_value); end
    endtask

    task automatic test_rename_commit();
        rename(5'd3, 4'd7);
        tick();
        idle_inputs();
        in_decoder_rs = 5'd3;
        in_decoder_rt = 5'd3;
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b1 || out_decoder_rs_reorder !== 4'd7) begin tests_failed++; $display("[TB] FAIL rename_x3: got busy %0b tag %0d want 1/7", out_decoder_rs_busy, out_decoder_rs_reorder); end
        tests_run++; if (out_decoder_rt_busy !== 1'b1 || out_decoder_rt_reorder !== 4'd7) begin tests_failed++; $display("[TB] FAIL rename_x3_rt: got busy %0b tag %0d want 1/7", out_decoder_rt_busy, out_decoder_rt_reorder); end
        commit(5'd3, 32'hDEADBEEF, 4'd7);
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b0 || out_decoder_rs_reorder !== 4'd0 || out_decoder_rs_value !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL bypass_x3: got busy %0b tag %0d value %h want 0/0/deadbeef", out_decoder_rs_busy, out_decoder_rs_reorder, out_decoder_rs_value); end
        tick();
        idle_inputs();
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b0 || out_decoder_rs_reorder !== 4'd0 || out_decoder_rs_value !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL stored_x3: got busy %0b tag %0d value %h want 0/0/deadbeef", out_decoder_rs_busy, out_decoder_rs_reorder, out_decoder_rs_value); end
    endtask

    task automatic test_stale_commit();
        rename(5'd4, 4'd2);
        tick();
        rename(5'd4, 4'd5);
        tick();
        idle_inputs();
        commit(5'd4, 32'h11, 4'd2);
        in_decoder_rs = 5'd4;
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b1 || out_decoder_rs_reorder !== 4'd5 || out_decoder_rs_value !== 32'd0) begin tests_failed++; $display("[TB] FAIL stale_no_bypass: got busy %0b tag %0d value %h want 1/5/0", out_decoder_rs_busy, out_decoder_rs_reorder, out_decoder_rs_value); end
        tick();
        idle_inputs();
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b1 || out_decoder_rs_reorder !== 4'd5 || out_decoder_rs_value !== 32'h11) begin tests_failed++; $display("[TB] FAIL stale_stored: got busy %0b tag %0d value %h want 1/5/11", out_decoder_rs_busy, out_decoder_rs_reorder, out_decoder_rs_value); end
        commit(5'd4, 32'h55, 4'd5);
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b0 || out_decoder_rs_value !== 32'h55) begin tests_failed++; $display("[TB] FAIL young_bypass: got busy %0b value %h want 0/55", out_decoder_rs_busy, out_decoder_rs_value); end
        tick();
        idle_inputs();
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b0 || out_decoder_rs_reorder !== 4'd0 || out_decoder_rs_value !== 32'h55) begin tests_failed++; $display("[TB] FAIL young_stored: got busy %0b tag %0d value %h want 0/0/55", out_decoder_rs_busy, out_decoder_rs_reorder, out_decoder_rs_value); end
    endtask

    task automatic test_simultaneous();
        rename(5'd6, 4'd3);
        tick();
        rename(5'd6, 4'd9);
        commit(5'd6, 32'h22, 4'd3);
        tick();
        idle_inputs();
        in_decoder_rs = 5'd6;
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b1 || out_decoder_rs_reorder !== 4'd9 || out_decoder_rs_value !== 32'h22) begin tests_failed++; $display("[TB] FAIL rename_beats_commit: got busy %0b tag %0d value %h want 1/9/22", out_decoder_rs_busy, out_decoder_rs_reorder, out_decoder_rs_value); end
    endtask

    task automatic test_flush();
        rename(5'd1, 4'd4);
        tick();
        rename(5'd2, 4'd8);
        tick();
        idle_inputs();
        in_flush_enable = 1'b1;
        commit(5'd1, 32'h40, 4'd4);
        rename(5'd7, 4'd9);
        tick();
        idle_inputs();
        in_decoder_rs = 5'd1;
        in_decoder_rt = 5'd2;
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b0 || out_decoder_rs_value !== 32'h40) begin tests_failed++; $display("[TB] FAIL flush_x1: got busy %0b value %h want 0/40", out_decoder_rs_busy, out_decoder_rs_value); end
        tests_run++; if (out_decoder_rt_busy !== 1'b0 || out_decoder_rt_reorder !== 4'd0) begin tests_failed++; $display("[TB] FAIL flush_x2: got busy %0b tag %0d want 0/0", out_decoder_rt_busy, out_decoder_rt_reorder); end
        in_decoder_rs = 5'd7;
        in_decoder_rt = 5'd6;
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b0 || out_decoder_rs_reorder !== 4'd0) begin tests_failed++; $display("[TB] FAIL flush_drop_rename_x7: got busy %0b tag %0d want 0/0", out_decoder_rs_busy, out_decoder_rs_reorder); end
        tests_run++; if (out_decoder_rt_busy !== 1'b0 || out_decoder_rt_value !== 32'h22) begin tests_failed++; $display("[TB] FAIL flush_x6: got busy %0b value %h want 0/22", out_decoder_rt_busy, out_decoder_rt_value); end
    endtask

    task automatic test_same_cycle_read();
        rename(5'd1, 4'd3);
        in_decoder_rs = 5'd1;
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b0 || out_decoder_rs_value !== 32'h40) begin tests_failed++; $display("[TB] FAIL rename_invisible: got busy %0b value %h want 0/40", out_decoder_rs_busy, out_decoder_rs_value); end
        tick();
        idle_inputs();
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b1 || out_decoder_rs_reorder !== 4'd3) begin tests_failed++; $display("[TB] FAIL rename_visible_next: got busy %0b tag %0d want 1/3", out_decoder_rs_busy, out_decoder_rs_reorder); end
    endtask

    task automatic test_x0_and_stall();
        rename(5'd0, 4'd5);
        commit(5'd0, 32'h99, 4'd0);
        in_decoder_rs = 5'd0;
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b0 || out_decoder_rs_value !== 32'd0) begin tests_failed++; $display("[TB] FAIL x0_bypass: got busy %0b value %h want 0/0", out_decoder_rs_busy, out_decoder_rs_value); end
        tick();
        idle_inputs();
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b0 || out_decoder_rs_reorder !== 4'd0 || out_decoder_rs_value !== 32'd0) begin tests_failed++; $display("[TB] FAIL x0_stored: got busy %0b tag %0d value %h want 0/0/0", out_decoder_rs_busy, out_decoder_rs_reorder, out_decoder_rs_value); end
        in_rdy = 1'b0;
        rename(5'd9, 4'd6);
        tick();
        idle_inputs();
        in_rdy = 1'b1;
        in_decoder_rs = 5'd9;
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b0 || out_decoder_rs_reorder !== 4'd0) begin tests_failed++; $display("[TB] FAIL stall_rename: got busy %0b tag %0d want 0/0", out_decoder_rs_busy, out_decoder_rs_reorder); end
        rename(5'd9, 4'd6);
        tick();
        idle_inputs();
        in_rdy = 1'b0;
        commit(5'd9, 32'h77, 4'd6);
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b1 || out_decoder_rs_value !== 32'd0) begin tests_failed++; $display("[TB] FAIL stall_no_bypass: got busy %0b value %h want 1/0", out_decoder_rs_busy, out_decoder_rs_value); end
        tick();
        idle_inputs();
        in_rdy = 1'b1;
        #1;
        tests_run++; if (out_decoder_rs_busy !== 1'b1 || out_decoder_rs_reorder !== 4'd6 || out_decoder_rs_value !== 32'd0) begin tests_failed++; $display("[TB] FAIL stall_commit_held: got busy %0b tag %0d value %h want 1/6/0", out_decoder_rs_busy, out_decoder_rs_reorder, out_decoder_rs_value); end
    endtask

    task automatic test_reset_wins();
        in_rst = 1'b0;
        in_rdy = 1'b0;
        commit(5'd3, 32'hABCD, 4'd0);
        rename(5'd9, 4'd1);
        tick();
        in_rst = 1'b1;
        in_rdy = 1'b1;
        idle_inputs();
        in_decoder_rs = 5'd3;
        in_decoder_rt = 5'd9;
        #1;
        tests_run++; if (out_decoder_rs_value !== 32'd0 || out_decoder_rs_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_clears_x3: got busy %0b value %h want 0/0", out_decoder_rs_busy, out_decoder_rs_value); end
        tests_run++; if (out_decoder_rt_busy !== 1'b0 || out_decoder_rt_reorder !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_clears_x9: got busy %0b tag %0d want 0/0", out_decoder_rt_busy, out_decoder_rt_reorder); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        in_decoder_rs = 5'd0;
        in_decoder_rt = 5'd0;
        test_reset();
        test_rename_commit();
        test_stale_commit();
        test_simultaneous();
        test_flush();
        test_same_cycle_read();
        test_x0_and_stall();
        test_reset_wins();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
